// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field layout,
// FSM/class encodings and the bundle of single-bit control outputs.
package cpu_pkg;

  localparam int OPC_W = 5;

  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_ADD  = 5'b00011;
  localparam logic [4:0] OPC_SUB  = 5'b00100;
  localparam logic [4:0] OPC_SHR  = 5'b00101;
  localparam logic [4:0] OPC_SHRA = 5'b00110;
  localparam logic [4:0] OPC_SHL  = 5'b00111;
  localparam logic [4:0] OPC_ROR  = 5'b01000;
  localparam logic [4:0] OPC_ROL  = 5'b01001;
  localparam logic [4:0] OPC_AND  = 5'b01010;
  localparam logic [4:0] OPC_OR   = 5'b01011;
  localparam logic [4:0] OPC_ADDI = 5'b01100;
  localparam logic [4:0] OPC_ANDI = 5'b01101;
  localparam logic [4:0] OPC_ORI  = 5'b01110;
  localparam logic [4:0] OPC_MUL  = 5'b01111;
  localparam logic [4:0] OPC_DIV  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;

  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_LSB = 15;
  localparam int IR_FLD_W  = 4;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_BINARY, CLS_IMM, CLS_MULDIV, CLS_UNARY, CLS_ILLEGAL
  } op_class_t;

  typedef struct packed {
    logic pc_out;
    logic zlo_out;
    logic zhi_out;
    logic mdr_out;
    logic c_out;
    logic mar_enable;
    logic pc_enable;
    logic pc_increment;
    logic mdr_enable;
    logic read;
    logic ir_enable;
    logic y_enable;
    logic z_enable;
    logic hi_enable;
    logic lo_enable;
    logic busy;
    logic done;
    logic illegal_op;
  } ctrl_t;

endpackage

// File: rtl/op_class_decoder.sv
// Combinational opcode-to-class lookup; anything not an ALU operation is ILLEGAL.
module op_class_decoder
  import cpu_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] i_opc,
  output op_class_t       o_cls
);

  localparam int XW = (OP_W > OPC_W) ? OP_W : OPC_W;

  logic [XW-1:0] w_opc;

  always_comb begin
    w_opc = XW'(i_opc);
    case (w_opc)
      XW'(OPC_ADD), XW'(OPC_SUB), XW'(OPC_SHR), XW'(OPC_SHRA), XW'(OPC_SHL),
      XW'(OPC_ROR), XW'(OPC_ROL), XW'(OPC_AND), XW'(OPC_OR):
        o_cls = CLS_BINARY;
      XW'(OPC_ADDI), XW'(OPC_ANDI), XW'(OPC_ORI):
        o_cls = CLS_IMM;
      XW'(OPC_MUL), XW'(OPC_DIV):
        o_cls = CLS_MULDIV;
      XW'(OPC_NEG), XW'(OPC_NOT):
        o_cls = CLS_UNARY;
      XW'(OPC_LD), XW'(OPC_LDI), XW'(OPC_ST):
        o_cls = CLS_ILLEGAL;
      default:
        o_cls = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired fetch/decode/execute control FSM for the 32-bit bus datapath.
// Outputs are registered, decoded from the state being entered on each edge.
module alu_control_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int STEP_CYCLES = 1,
  parameter int OP_W        = 5
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                mdr_out,
  output logic                c_out,
  output logic                mar_enable,
  output logic                pc_enable,
  output logic                pc_increment,
  output logic                mdr_enable,
  output logic                read,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                hi_enable,
  output logic                lo_enable,
  output logic [NUM_REGS-1:0] reg_in_sel,
  output logic [NUM_REGS-1:0] reg_out_sel,
  output logic [OP_W-1:0]     op_code,
  output logic                busy,
  output logic                done,
  output logic                illegal_op
);

  localparam logic [3:0] STEP_LAST = 4'(STEP_CYCLES - 1);

  state_t                r_state, w_next;
  logic [3:0]            r_step, w_step_nxt;
  logic                  w_step_done, w_enter;
  logic                  r_mem_seen;
  op_class_t             w_cls_live, r_cls, w_cls;
  logic [IR_FLD_W-1:0]   r_ra, r_rb, r_rc, w_ra, w_rb, w_rc;
  logic [OP_W-1:0]       r_opc, w_opc;
  logic                  w_use_live;
  ctrl_t                 w_ctl, r_ctl;
  logic [NUM_REGS-1:0]   w_in_sel, w_out_sel, r_in_sel, r_out_sel;
  logic [OP_W-1:0]       w_op_out, r_op_out;
  logic                  w_unused;

  assign w_unused = ^ir[IR_RC_LSB-1:0];

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IR_FLD_W-1:0] f);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (int'(f) < NUM_REGS) v = NUM_REGS'(1) << f;
    return v;
  endfunction

  op_class_decoder #(.OP_W(OP_W)) u_dec (
    .i_opc (ir[31:32-OP_W]),
    .o_cls (w_cls_live)
  );

  // IR is sampled live on the edge into T3 and from the latched copy afterwards.
  assign w_use_live = (r_state == S_T2);
  assign w_cls      = w_use_live ? w_cls_live : r_cls;
  assign w_opc      = w_use_live ? ir[31:32-OP_W] : r_opc;
  assign w_ra       = w_use_live ? ir[IR_RA_LSB +: IR_FLD_W] : r_ra;
  assign w_rb       = w_use_live ? ir[IR_RB_LSB +: IR_FLD_W] : r_rb;
  assign w_rc       = w_use_live ? ir[IR_RC_LSB +: IR_FLD_W] : r_rc;

  always_comb begin
    w_step_done = (r_step == STEP_LAST);
    w_next      = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_T0;
      S_T0:   if (w_step_done) w_next = S_T1;
      // Leave the read step only once memory data has been captured.
      S_T1:   if (w_step_done && r_mem_seen) w_next = S_T2;
      S_T2:   if (w_step_done) w_next = S_T3;
      S_T3: begin
        if (r_cls == CLS_ILLEGAL)  w_next = S_IDLE;
        else if (w_step_done)      w_next = S_T4;
      end
      S_T4:   if (w_step_done) w_next = (r_cls == CLS_UNARY) ? S_DONE : S_T5;
      S_T5:   if (w_step_done) w_next = (r_cls == CLS_MULDIV) ? S_T6 : S_DONE;
      S_T6:   if (w_step_done) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase

    w_enter = (w_next != r_state);
    if (w_enter)          w_step_nxt = '0;
    else if (w_step_done) w_step_nxt = r_step;
    else                  w_step_nxt = r_step + 4'd1;
  end

  always_comb begin
    w_ctl      = '0;
    w_in_sel   = '0;
    w_out_sel  = '0;
    w_op_out   = '0;
    w_ctl.busy = (w_next != S_IDLE);
    case (w_next)
      S_T0: begin
        w_ctl.pc_out       = 1'b1;
        w_ctl.mar_enable   = 1'b1;
        w_ctl.z_enable     = 1'b1;
        w_ctl.pc_increment = w_enter;
      end
      S_T1: begin
        w_ctl.zlo_out    = 1'b1;
        w_ctl.pc_enable  = 1'b1;
        w_ctl.read       = 1'b1;
        w_ctl.mdr_enable = mem_ready && !r_mem_seen;
      end
      S_T2: begin
        w_ctl.mdr_out   = 1'b1;
        w_ctl.ir_enable = 1'b1;
      end
      S_T3: begin
        case (w_cls)
          CLS_ILLEGAL: w_ctl.illegal_op = 1'b1;
          CLS_UNARY: begin
            w_out_sel      = onehot(w_rb);
            w_op_out       = w_opc;
            w_ctl.z_enable = 1'b1;
          end
          default: begin
            w_out_sel      = onehot(w_rb);
            w_ctl.y_enable = 1'b1;
          end
        endcase
      end
      S_T4: begin
        w_op_out = w_opc;
        case (w_cls)
          CLS_UNARY: begin
            w_ctl.zlo_out = 1'b1;
            w_in_sel      = onehot(w_ra);
          end
          CLS_IMM: begin
            w_ctl.c_out    = 1'b1;
            w_ctl.z_enable = 1'b1;
          end
          default: begin
            w_out_sel      = onehot(w_rc);
            w_ctl.z_enable = 1'b1;
          end
        endcase
      end
      S_T5: begin
        w_op_out      = w_opc;
        w_ctl.zlo_out = 1'b1;
        if (w_cls == CLS_MULDIV) w_ctl.lo_enable = 1'b1;
        else                     w_in_sel        = onehot(w_ra);
      end
      S_T6: begin
        w_op_out        = w_opc;
        w_ctl.zhi_out   = 1'b1;
        w_ctl.hi_enable = 1'b1;
      end
      S_DONE: begin
        w_op_out   = w_opc;
        w_ctl.done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_mem_seen <= 1'b0;
      r_cls      <= CLS_ILLEGAL;
      r_ctl      <= '0;
      r_in_sel   <= '0;
      r_out_sel  <= '0;
      r_op_out   <= '0;
    end else begin
      r_state    <= w_next;
      r_step     <= w_step_nxt;
      r_mem_seen <= (w_next == S_T1) && (r_mem_seen || mem_ready);
      if (r_state == S_T2) r_cls <= w_cls_live;
      r_ctl      <= w_ctl;
      r_in_sel   <= w_in_sel;
      r_out_sel  <= w_out_sel;
      r_op_out   <= w_op_out;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_T2) begin
      r_opc <= ir[31:32-OP_W];
      r_ra  <= ir[IR_RA_LSB +: IR_FLD_W];
      r_rb  <= ir[IR_RB_LSB +: IR_FLD_W];
      r_rc  <= ir[IR_RC_LSB +: IR_FLD_W];
    end
  end

  assign pc_out       = r_ctl.pc_out;
  assign zlo_out      = r_ctl.zlo_out;
  assign zhi_out      = r_ctl.zhi_out;
  assign mdr_out      = r_ctl.mdr_out;
  assign c_out        = r_ctl.c_out;
  assign mar_enable   = r_ctl.mar_enable;
  assign pc_enable    = r_ctl.pc_enable;
  assign pc_increment = r_ctl.pc_increment;
  assign mdr_enable   = r_ctl.mdr_enable;
  assign read         = r_ctl.read;
  assign ir_enable    = r_ctl.ir_enable;
  assign y_enable     = r_ctl.y_enable;
  assign z_enable     = r_ctl.z_enable;
  assign hi_enable    = r_ctl.hi_enable;
  assign lo_enable    = r_ctl.lo_enable;
  assign busy         = r_ctl.busy;
  assign done         = r_ctl.done;
  assign illegal_op   = r_ctl.illegal_op;
  assign reg_in_sel   = r_in_sel;
  assign reg_out_sel  = r_out_sel;
  assign op_code      = r_op_out;

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Bench for alu_control_sequencer: two instances (1-cycle steps/16 regs and
// 2-cycle steps/12 regs) compared cycle by cycle against an expected trace.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, c_out;
    logic mar_enable, pc_enable, pc_increment, mdr_enable, rd;
    logic ir_enable, y_enable, z_enable, hi_enable, lo_enable;
    logic busy, done, illegal_op;
    logic [4:0]  op;
    logic [15:0] in_sel;
    logic [15:0] out_sel;
  } obs_t;

  logic        clk = 1'b0, clr = 1'b0, start = 1'b0;
  logic        mem_ready_a = 1'b0, mem_ready_b = 1'b0;
  logic [31:0] ir = '0;

  logic a_pc_out, a_zlo_out, a_zhi_out, a_mdr_out, a_c_out, a_mar_enable, a_pc_enable;
  logic a_pc_increment, a_mdr_enable, a_read, a_ir_enable, a_y_enable, a_z_enable;
  logic a_hi_enable, a_lo_enable, a_busy, a_done, a_illegal_op;
  logic [15:0] a_in_sel, a_out_sel;
  logic [4:0]  a_op;

  logic b_pc_out, b_zlo_out, b_zhi_out, b_mdr_out, b_c_out, b_mar_enable, b_pc_enable;
  logic b_pc_increment, b_mdr_enable, b_read, b_ir_enable, b_y_enable, b_z_enable;
  logic b_hi_enable, b_lo_enable, b_busy, b_done, b_illegal_op;
  logic [11:0] b_in_sel, b_out_sel;
  logic [4:0]  b_op;

  obs_t obs_a, obs_b;
  obs_t exp_q[2][$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_control_sequencer #(.NUM_REGS(16), .STEP_CYCLES(1), .OP_W(5)) u_dut_a (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready_a),
    .pc_out(a_pc_out), .zlo_out(a_zlo_out), .zhi_out(a_zhi_out), .mdr_out(a_mdr_out),
    .c_out(a_c_out), .mar_enable(a_mar_enable), .pc_enable(a_pc_enable),
    .pc_increment(a_pc_increment), .mdr_enable(a_mdr_enable), .read(a_read),
    .ir_enable(a_ir_enable), .y_enable(a_y_enable), .z_enable(a_z_enable),
    .hi_enable(a_hi_enable), .lo_enable(a_lo_enable), .reg_in_sel(a_in_sel),
    .reg_out_sel(a_out_sel), .op_code(a_op), .busy(a_busy), .done(a_done),
    .illegal_op(a_illegal_op)
  );

  alu_control_sequencer #(.NUM_REGS(12), .STEP_CYCLES(2), .OP_W(5)) u_dut_b (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .mem_ready(mem_ready_b),
    .pc_out(b_pc_out), .zlo_out(b_zlo_out), .zhi_out(b_zhi_out), .mdr_out(b_mdr_out),
    .c_out(b_c_out), .mar_enable(b_mar_enable), .pc_enable(b_pc_enable),
    .pc_increment(b_pc_increment), .mdr_enable(b_mdr_enable), .read(b_read),
    .ir_enable(b_ir_enable), .y_enable(b_y_enable), .z_enable(b_z_enable),
    .hi_enable(b_hi_enable), .lo_enable(b_lo_enable), .reg_in_sel(b_in_sel),
    .reg_out_sel(b_out_sel), .op_code(b_op), .busy(b_busy), .done(b_done),
    .illegal_op(b_illegal_op)
  );

  assign obs_a = {a_pc_out, a_zlo_out, a_zhi_out, a_mdr_out, a_c_out, a_mar_enable,
                  a_pc_enable, a_pc_increment, a_mdr_enable, a_read, a_ir_enable,
                  a_y_enable, a_z_enable, a_hi_enable, a_lo_enable, a_busy, a_done,
                  a_illegal_op, a_op, a_in_sel, a_out_sel};
  assign obs_b = {b_pc_out, b_zlo_out, b_zhi_out, b_mdr_out, b_c_out, b_mar_enable,
                  b_pc_enable, b_pc_increment, b_mdr_enable, b_read, b_ir_enable,
                  b_y_enable, b_z_enable, b_hi_enable, b_lo_enable, b_busy, b_done,
                  b_illegal_op, b_op, 16'(b_in_sel), 16'(b_out_sel)};

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] oh(input int f, input int nr);
    return (f < nr) ? (16'd1 << f) : 16'd0;
  endfunction

  // Expected per-cycle output trace of one instruction, from the step table.
  task automatic build(input int k, input logic [31:0] iv, input int s, input int w, input int nr);
    int   opc, ra, rb, rc, cls, t1len;
    obs_t e;
    opc = int'(iv[31:27]);
    ra  = int'(iv[26:23]);
    rb  = int'(iv[22:19]);
    rc  = int'(iv[18:15]);
    if (opc >= 3 && opc <= 11)       cls = 0;
    else if (opc >= 12 && opc <= 14) cls = 1;
    else if (opc == 15 || opc == 16) cls = 2;
    else if (opc == 17 || opc == 18) cls = 3;
    else                             cls = 4;
    t1len = (w + 1 > s) ? w + 1 : s;
    exp_q[k].delete();
    for (int i = 0; i < s; i++) begin
      e = '0; e.busy = 1; e.pc_out = 1; e.mar_enable = 1; e.z_enable = 1;
      e.pc_increment = (i == 0);
      exp_q[k].push_back(e);
    end
    for (int i = 0; i < t1len; i++) begin
      e = '0; e.busy = 1; e.zlo_out = 1; e.pc_enable = 1; e.rd = 1;
      e.mdr_enable = (i == w);
      exp_q[k].push_back(e);
    end
    for (int i = 0; i < s; i++) begin
      e = '0; e.busy = 1; e.mdr_out = 1; e.ir_enable = 1;
      exp_q[k].push_back(e);
    end
    if (cls == 4) begin
      e = '0; e.busy = 1; e.illegal_op = 1;
      exp_q[k].push_back(e);
    end else begin
      for (int i = 0; i < s; i++) begin
        e = '0; e.busy = 1; e.out_sel = oh(rb, nr);
        if (cls == 3) begin e.op = 5'(opc); e.z_enable = 1; end
        else e.y_enable = 1;
        exp_q[k].push_back(e);
      end
      for (int i = 0; i < s; i++) begin
        e = '0; e.busy = 1; e.op = 5'(opc);
        if (cls == 3) begin e.zlo_out = 1; e.in_sel = oh(ra, nr); end
        else if (cls == 1) begin e.c_out = 1; e.z_enable = 1; end
        else begin e.out_sel = oh(rc, nr); e.z_enable = 1; end
        exp_q[k].push_back(e);
      end
      if (cls != 3)
        for (int i = 0; i < s; i++) begin
          e = '0; e.busy = 1; e.op = 5'(opc); e.zlo_out = 1;
          if (cls == 2) e.lo_enable = 1;
          else e.in_sel = oh(ra, nr);
          exp_q[k].push_back(e);
        end
      if (cls == 2)
        for (int i = 0; i < s; i++) begin
          e = '0; e.busy = 1; e.op = 5'(opc); e.zhi_out = 1; e.hi_enable = 1;
          exp_q[k].push_back(e);
        end
      e = '0; e.busy = 1; e.done = 1; e.op = 5'(opc);
      exp_q[k].push_back(e);
    end
    e = '0;
    exp_q[k].push_back(e);
  endtask

  task automatic run_instr(input logic [31:0] iv, input int wa, input int wb,
                           input bit stray, input string nm);
    int len;
    build(0, iv, 1, wa, 16);
    build(1, iv, 2, wb, 12);
    len = (exp_q[0].size() > exp_q[1].size()) ? exp_q[0].size() : exp_q[1].size();
    @(negedge clk);
    ir    = iv;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= len; n++) begin
      @(negedge clk);
      start       = stray && (n == 2);
      mem_ready_a = (n >= 1 + wa);
      mem_ready_b = (n >= 2 + wb);
      if (n <= exp_q[0].size())
        check_eq($sformatf("%s a c%0d", nm, n), 64'(obs_a), 64'(exp_q[0][n-1]));
      if (n <= exp_q[1].size())
        check_eq($sformatf("%s b c%0d", nm, n), 64'(obs_b), 64'(exp_q[1][n-1]));
    end
    @(negedge clk);
    start       = 1'b0;
    mem_ready_a = 1'b0;
    mem_ready_b = 1'b0;
  endtask

  task automatic clr_mid_t4();
    build(0, 32'h51918000, 1, 0, 16);
    build(1, 32'h51918000, 2, 0, 12);
    @(negedge clk);
    ir    = 32'h51918000;
    start = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      start       = 1'b0;
      mem_ready_a = 1'b1;
      mem_ready_b = (n >= 2);
      check_eq($sformatf("pre_clr a c%0d", n), 64'(obs_a), 64'(exp_q[0][n-1]));
      check_eq($sformatf("pre_clr b c%0d", n), 64'(obs_b), 64'(exp_q[1][n-1]));
    end
    #1 clr = 1'b1;
    #1;
    check_eq("clr_async a", 64'(obs_a), 64'd0);
    check_eq("clr_async b", 64'(obs_b), 64'd0);
    @(negedge clk);
    check_eq("clr_hold a", 64'(obs_a), 64'd0);
    clr         = 1'b0;
    mem_ready_a = 1'b0;
    mem_ready_b = 1'b0;
    @(negedge clk);
    check_eq("post_clr a", 64'(obs_a), 64'd0);
    check_eq("post_clr b", 64'(obs_b), 64'd0);
  endtask

  initial begin
    logic [31:0] rv;
    int          opc;
    #1 clr = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset a", 64'(obs_a), 64'd0);
    check_eq("reset b", 64'(obs_b), 64'd0);
    clr = 1'b0;

    run_instr(32'h51918000, 0, 0, 1'b0, "and");
    run_instr(32'h90900000, 0, 0, 1'b0, "not");
    run_instr(32'h78118000, 0, 0, 1'b0, "mul");
    run_instr(32'h51918000, 5, 5, 1'b0, "memwait");
    run_instr(32'h00000000, 0, 0, 1'b0, "ld");
    run_instr(32'h51918000, 0, 0, 1'b1, "stray_start");
    run_instr({5'd3, 4'd13, 4'd12, 4'd15, 15'd0}, 0, 0, 1'b0, "hireg");
    run_instr({5'd14, 4'd11, 4'd12, 4'd0, 15'd0}, 1, 0, 1'b0, "ori");
    clr_mid_t4();
    run_instr(32'h51918000, 0, 0, 1'b0, "after_clr");

    for (int i = 0; i < 40; i++) begin
      rv = $urandom;
      if ($urandom_range(0, 3) != 0) opc = $urandom_range(3, 18);
      else                           opc = $urandom_range(0, 31);
      rv[31:27] = 5'(opc);
      run_instr(rv, $urandom_range(0, 5), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
